// File: rtl/cdb_writeback_arbiter_pkg.sv
// ============================================================================
// Module      : cdb_writeback_arbiter_pkg
// Description : Shared types and unit indices for the CDB writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_writeback_arbiter_pkg;

   localparam int CDB_ROB_IDX_WIDTH = 5;

   localparam int FU_ALU = 0;
   localparam int FU_MUL = 1;
   localparam int FU_BR  = 2;
   localparam int FU_MEM = 3;

   typedef struct packed {
      logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
      logic [4:0]                   rd_addr;
      logic [31:0]                  data;
      logic                         regf_we;
   } cdb_result_t;

endpackage

`default_nettype wire

// File: rtl/cdb_result_fifo.sv
// ============================================================================
// Module      : cdb_result_fifo
// Description : Per-unit result FIFO; simultaneous push and pop keep order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_result_fifo
   import cdb_writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  cdb_result_t push_data,
   output logic        full,
   output logic        empty,
   output cdb_result_t head
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   cdb_result_t        r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push)
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (pop)
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         r_mem[r_wr_ptr] <= push_data;
   end

   assign full  = (r_count == c_cnt_w'(DEPTH));
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/cdb_writeback_arbiter.sv
// ============================================================================
// Module      : cdb_writeback_arbiter
// Description : Buffers per-unit results and broadcasts one per cycle on a
//               registered CDB. CDB_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_writeback_arbiter
   import cdb_writeback_arbiter_pkg::*;
#(
   parameter int NUM_FU        = 4,
   parameter int ROB_IDX_WIDTH = CDB_ROB_IDX_WIDTH,
   parameter int BUF_DEPTH     = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [NUM_FU-1:0]                 fu_valid,
   output logic [NUM_FU-1:0]                 fu_ready,
   input  logic [NUM_FU*ROB_IDX_WIDTH-1:0]   fu_rob_idx,
   input  logic [NUM_FU*5-1:0]               fu_rd_addr,
   input  logic [NUM_FU*32-1:0]              fu_data,
   input  logic [NUM_FU-1:0]                 fu_regf_we,
   output logic                              cdb_valid,
   output logic [$clog2(NUM_FU)-1:0]         cdb_src,
   output logic [ROB_IDX_WIDTH-1:0]          cdb_rob_idx,
   output logic [4:0]                        cdb_rd_addr,
   output logic [31:0]                       cdb_data,
   output logic                              cdb_regf_we
);

   localparam int c_src_w = $clog2(NUM_FU);

   logic [NUM_FU-1:0]  w_full;
   logic [NUM_FU-1:0]  w_empty;
   logic [NUM_FU-1:0]  w_push;
   logic [NUM_FU-1:0]  w_pop;
   cdb_result_t        w_in   [NUM_FU];
   cdb_result_t        w_head [NUM_FU];
   cdb_result_t        w_sel;
   logic               w_grant;
   logic [c_src_w-1:0] w_grant_idx;
   logic [c_src_w-1:0] w_cand;

   generate
      for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
         assign w_in[i] = {CDB_ROB_IDX_WIDTH'(fu_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]),
                           fu_rd_addr[i*5 +: 5],
                           fu_data[i*32 +: 32],
                           fu_regf_we[i]};
         assign w_push[i] = fu_valid[i] && !w_full[i] && !flush;
         assign w_pop[i]  = w_grant && (w_grant_idx == c_src_w'(i));

         cdb_result_fifo #(
            .DEPTH (BUF_DEPTH)
         ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push[i]),
            .pop       (w_pop[i]),
            .flush     (flush),
            .push_data (w_in[i]),
            .full      (w_full[i]),
            .empty     (w_empty[i]),
            .head      (w_head[i])
         );
      end
   endgenerate

   // Ready comes from registered FIFO occupancy only, never from this cycle's grant.
   assign fu_ready = ~w_full;

`ifndef CDB_ARB_FIXED_PRIO_EN
   logic [c_src_w-1:0] r_rr_ptr;
   logic [c_src_w-1:0] w_next_ptr;

   assign w_next_ptr = (w_grant_idx == c_src_w'(NUM_FU-1)) ? '0 : w_grant_idx + c_src_w'(1);

   always_ff @(posedge clk) begin
      if (rst || flush)
         r_rr_ptr <= '0;
      else if (w_grant)
         r_rr_ptr <= w_next_ptr;
   end
`endif

   always_comb begin
      w_grant     = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      for (int k = 0; k < NUM_FU; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
         w_cand = c_src_w'(k);
`else
         w_cand = c_src_w'((int'(r_rr_ptr) + k) % NUM_FU);
`endif
         if (!w_grant && !w_empty[w_cand]) begin
            w_grant     = 1'b1;
            w_grant_idx = w_cand;
         end
      end
   end

   assign w_sel = w_head[w_grant_idx];

   always_ff @(posedge clk) begin
      if (rst || flush || !w_grant) begin
         cdb_valid   <= 1'b0;
         cdb_src     <= '0;
         cdb_rob_idx <= '0;
         cdb_rd_addr <= '0;
         cdb_data    <= '0;
         cdb_regf_we <= 1'b0;
      end else begin
         cdb_valid   <= 1'b1;
         cdb_src     <= w_grant_idx;
         cdb_rob_idx <= ROB_IDX_WIDTH'(w_sel.rob_idx);
         cdb_rd_addr <= w_sel.rd_addr;
         cdb_data    <= w_sel.data;
         // Writes to x0 are never architecturally visible.
         cdb_regf_we <= w_sel.regf_we && (w_sel.rd_addr != 5'd0);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cdb_writeback_arbiter.sv
// ============================================================================
// Module      : tb_cdb_writeback_arbiter
// Description : Scoreboard bench for cdb_writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_writeback_arbiter;

   localparam int NUM_FU = 4;
   localparam int RW     = 5;

   logic                   clk;
   logic                   rst;
   logic                   flush;
   logic [NUM_FU-1:0]      fu_valid;
   logic [NUM_FU-1:0]      fu_ready;
   logic [NUM_FU*RW-1:0]   fu_rob_idx;
   logic [NUM_FU*5-1:0]    fu_rd_addr;
   logic [NUM_FU*32-1:0]   fu_data;
   logic [NUM_FU-1:0]      fu_regf_we;
   logic                   cdb_valid;
   logic [1:0]             cdb_src;
   logic [RW-1:0]          cdb_rob_idx;
   logic [4:0]             cdb_rd_addr;
   logic [31:0]            cdb_data;
   logic                   cdb_regf_we;

   cdb_writeback_arbiter #(
      .NUM_FU        (NUM_FU),
      .ROB_IDX_WIDTH (RW),
      .BUF_DEPTH     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .fu_valid    (fu_valid),
      .fu_ready    (fu_ready),
      .fu_rob_idx  (fu_rob_idx),
      .fu_rd_addr  (fu_rd_addr),
      .fu_data     (fu_data),
      .fu_regf_we  (fu_regf_we),
      .cdb_valid   (cdb_valid),
      .cdb_src     (cdb_src),
      .cdb_rob_idx (cdb_rob_idx),
      .cdb_rd_addr (cdb_rd_addr),
      .cdb_data    (cdb_data),
      .cdb_regf_we (cdb_regf_we)
   );

   typedef struct {
      logic [1:0]  src;
      logic [4:0]  rob;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] src_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input logic [4:0] rob, input logic [4:0] rd,
                        input logic [31:0] data, input logic we);
      fu_valid[u]          = 1'b1;
      fu_rob_idx[u*RW +: RW] = rob;
      fu_rd_addr[u*5 +: 5] = rd;
      fu_data[u*32 +: 32]  = data;
      fu_regf_we[u]        = we;
   endtask

   task automatic expect_res(input int u, input logic [4:0] rob, input logic [4:0] rd,
                             input logic [31:0] data, input logic we, input bit ordered);
      exp_t e;
      e.src  = 2'(u);
      e.rob  = rob;
      e.rd   = rd;
      e.data = data;
      e.we   = we;
      exp_q.push_back(e);
      if (ordered)
         src_q.push_back(2'(u));
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         step();
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      src_q.delete();
   endtask

   // Monitor: every broadcast must match the oldest pending result of its unit.
   always @(negedge clk) begin
      int   found;
      exp_t e;
      if (!rst && cdb_valid) begin
         found = -1;
         for (int j = 0; j < exp_q.size(); j++)
            if (found < 0 && exp_q[j].src == cdb_src)
               found = j;
         if (found < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_broadcast: got src %0d rob %0d data %h, expected none",
                     cdb_src, cdb_rob_idx, cdb_data);
         end else begin
            e = exp_q[found];
            exp_q.delete(found);
            check("cdb_payload",
                  {19'd0, cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we},
                  {19'd0, e.src, e.rob, e.rd, e.data, e.we});
         end
         if (src_q.size() > 0)
            check("grant_order", 64'(cdb_src), 64'(src_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  s0, s1, guard;
      bit  a0, a1, saw_low;

      rst        = 1'b1;
      flush      = 1'b0;
      fu_valid   = '0;
      fu_rob_idx = '0;
      fu_rd_addr = '0;
      fu_data    = '0;
      fu_regf_we = '0;

      // Reset
      step();
      step();
      rst = 1'b0;
      step();
      check("reset_valid", 64'(cdb_valid), 64'd0);
      check("reset_ready", 64'(fu_ready), 64'hf);
      check("reset_fields", {cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we}, 64'd0);

      // Single ALU result: one-cycle latency, then idle
      expect_res(0, 5'd5, 5'd3, 32'hDEADBEEF, 1'b1, 1'b1);
      drive(0, 5'd5, 5'd3, 32'hDEADBEEF, 1'b1);
      step();
      fu_valid = '0;
      check("single_not_yet", 64'(cdb_valid), 64'd0);
      step();
      check("single_valid", 64'(cdb_valid), 64'd1);
      step();
      check("single_idle", 64'(cdb_valid), 64'd0);
      wait_drain(4);

      // All four units at once with the pointer at 0
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int u = 0; u < 4; u++) begin
         drive(u, 5'(10 + u), 5'(u + 1), 32'h100 + 32'(u), 1'b1);
         expect_res(u, 5'(10 + u), 5'(u + 1), 32'h100 + 32'(u), 1'b1, 1'b1);
      end
      step();
      fu_valid = '0;
      wait_drain(10);

      // Backpressure: units 0 and 1 each stream items 1..6
      for (int k = 1; k <= 6; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
         expect_res(0, 5'(k), 5'(k), 32'(k), 1'b1, 1'b0);
         expect_res(1, 5'(8 + k), 5'(k), 32'(k), 1'b1, 1'b0);
`else
         expect_res(0, 5'(k), 5'(k), 32'(k), 1'b1, 1'b1);
         expect_res(1, 5'(8 + k), 5'(k), 32'(k), 1'b1, 1'b1);
`endif
      end
      s0 = 1; s1 = 1; guard = 0; saw_low = 1'b0;
      while ((s0 <= 6 || s1 <= 6) && guard < 40) begin
         fu_valid[0] = 1'b0;
         fu_valid[1] = 1'b0;
         if (s0 <= 6) drive(0, 5'(s0), 5'(s0), 32'(s0), 1'b1);
         if (s1 <= 6) drive(1, 5'(8 + s1), 5'(s1), 32'(s1), 1'b1);
         a0 = fu_valid[0] && fu_ready[0];
         a1 = fu_valid[1] && fu_ready[1];
         if (!fu_ready[0]) saw_low = 1'b1;
         step();
         if (a0) s0++;
         if (a1) s1++;
         guard++;
      end
      fu_valid = '0;
      check("bp_all_accepted", 64'(guard < 40), 64'd1);
      check("bp_ready0_dropped", 64'(saw_low), 64'd1);
      wait_drain(20);

      // Flush with unit 2 full: only the in-flight unit-0 broadcast survives
      flush = 1'b1;
      step();
      flush = 1'b0;
      expect_res(0, 5'd1, 5'd1, 32'hA0, 1'b1, 1'b1);
      drive(0, 5'd1, 5'd1, 32'hA0, 1'b1);
      drive(1, 5'd2, 5'd2, 32'hA1, 1'b1);
      drive(2, 5'd3, 5'd3, 32'hB0, 1'b1);
      step();
      fu_valid = '0;
      drive(2, 5'd4, 5'd4, 32'hB1, 1'b1);
      step();
      check("flush_mid_valid", 64'(cdb_valid), 64'd1);
      check("flush_mid_ready", 64'(fu_ready), 64'b1011);
      fu_valid = '0;
      flush = 1'b1;
      drive(3, 5'd6, 5'd6, 32'hC0, 1'b1);
      step();
      flush = 1'b0;
      fu_valid = '0;
      check("flush_valid", 64'(cdb_valid), 64'd0);
      check("flush_ready", 64'(fu_ready), 64'hf);
      check("flush_data", 64'(cdb_data), 64'd0);
      for (int c = 0; c < 5; c++) step();
      wait_drain(1);

      // rd x0 suppresses the register write but keeps the data
      expect_res(3, 5'd7, 5'd0, 32'h55, 1'b0, 1'b1);
      drive(3, 5'd7, 5'd0, 32'h55, 1'b1);
      step();
      fu_valid = '0;
      wait_drain(5);
      for (int c = 0; c < 3; c++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cdb_writeback_arbiter.md
# cdb_writeback_arbiter

Producer end of the common data bus that dispatch/issue and the reservation stations snoop. It sits between the four execution units (ALU, MUL/DIV, branch, memory) and the shared CDB. It accepts one completed result per unit per cycle into a small per-unit FIFO. Each cycle it grants one buffered result and drives it onto a registered single-result bus carrying valid, source, ROB index, rd address, data and write enable.

## Interface
Parameters:
- NUM_FU, 4, number of producing units; index 0=alu, 1=mul, 2=br, 3=mem
- ROB_IDX_WIDTH, 5, ROB index width
- BUF_DEPTH, 2, entries per unit FIFO (power of two, ≥2)

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict flush; discards all buffered and in-flight results
- fu_valid  in  NUM_FU  unit i presents a result
- fu_ready  out  NUM_FU  unit i FIFO can accept this cycle
- fu_rob_idx  in  NUM_FU*ROB_IDX_WIDTH  packed ROB indices
- fu_rd_addr  in  NUM_FU*5  packed destination registers
- fu_data  in  NUM_FU*32  packed result data
- fu_regf_we  in  NUM_FU  result writes a register
- cdb_valid  out  1  broadcast valid
- cdb_src  out  $clog2(NUM_FU)  granted unit index
- cdb_rob_idx  out  ROB_IDX_WIDTH
- cdb_rd_addr  out  5
- cdb_data  out  32
- cdb_regf_we  out  1

## Operation
- Push: a result is accepted when fu_valid[i] && fu_ready[i] && !flush.
- fu_ready[i] = (count[i] != BUF_DEPTH). It is registered state only and never depends on this cycle's grant.
- Pop and push on the same FIFO in the same cycle are legal. Count is unchanged and FIFO order is preserved.
- Arbitration considers only non-empty FIFO heads. Round-robin search starts at rr_ptr.
- On a grant to unit g, rr_ptr <= (g+1) mod NUM_FU. With no grant, rr_ptr holds.
- The granted head is popped and registered onto the cdb_* outputs.
- Without a grant, cdb_valid <= 0. The other cdb_* fields are zeroed.
- Register-write suppression: cdb_regf_we = head.regf_we && (head.rd_addr != 0). cdb_rd_addr and cdb_data pass through unchanged.
- flush: all counts, FIFO pointers and cdb_valid are cleared on the next edge. Pushes in the flush cycle are dropped. rr_ptr resets to 0.
- Inputs with fu_valid set while fu_ready is low are ignored. Units must hold the result until it is accepted.

## Timing
- Reset values: cdb_valid=0, all cdb_* fields = 0, rr_ptr=0, counts=0, fu_ready = all ones from the first cycle after reset.
- Latency: a result pushed at edge N is broadcast at edge N+1 at the earliest. It is visible to consumers during cycle N+1.
- Throughput: one broadcast per cycle in aggregate.
- Starvation bound: a non-empty head is granted within NUM_FU cycles.
- fu_ready deasserts the cycle after count reaches BUF_DEPTH. It reasserts the cycle after that unit's pop.
- flush mid-broadcast: the current cdb_valid cycle completes; the next cycle shows cdb_valid=0.
- rst overrides flush and all pushes.

## Configuration
- CDB_ARB_FIXED_PRIO_EN defined: rr_ptr is removed and arbitration is fixed priority, lowest index first (alu over mul over br over mem). The starvation bound no longer applies.
- Not defined: round-robin as described above.

## Structure
- rv32i_types gains the following shared definitions:
  - typedef cdb_result_t {rob_idx, rd_addr, data, regf_we}
  - localparams FU_ALU=0, FU_MUL=1, FU_BR=2, FU_MEM=3
- Sub-module cdb_result_fifo: parameterised depth, one instance per unit. Its ports are push, pop, flush, full, empty and head (cdb_result_t).
- The top level holds the arbiter, rr_ptr and output register.

## Test plan
- Reset: assert rst for 2 cycles, then release -> cdb_valid=0 and fu_ready=4'b1111 on the first post-reset cycle.
- Single result: at cycle 1, alu valid with rob 5, rd x3, data 0xDEADBEEF, we 1 -> cycle 2 shows cdb_valid=1, src 0, rob 5, rd 3, data 0xDEADBEEF, we 1; cycle 3 shows cdb_valid=0.
- All four units valid in the same cycle with rr_ptr=0 -> broadcasts over 4 consecutive cycles with src 0,1,2,3. Under the macro with alternating pushes, unit 0 always wins first.
- Backpressure: units 0 and 1 push every cycle for 6 cycles, with distinct data 1..6 on each unit.
  - Broadcasts alternate between unit 0 and unit 1.
  - fu_ready[0] drops after the FIFO fills.
  - Per-unit data order is 1..6 with no loss.
- Flush: fill unit 2 with 2 entries, then assert flush -> next cycle cdb_valid=0 and fu_ready=4'b1111. None of the flushed data ever appears.
- rd x0: mem result with rd 0, we 1, data 0x55 -> broadcast shows we 0 and data 0x55.
